// File: rtl/branch_predictor_if.sv
// Interface between the pipeline and branch_predictor.
// Carries the IF lookup, the EX resolve/training port, and the statistics counters.
// The master modport is the pipeline side and the slave modport is the predictor side.
interface branch_predictor_if;
    // IF-stage lookup
    logic [31:0] if_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;

    // EX-stage resolve / training
    logic        ex_upd_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;

    // Statistics
    logic [31:0] br_count;
    logic [31:0] mis_count;

    modport master (
        output if_pc, ex_upd_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_hit, pred_taken, pred_target, mispredict, br_count, mis_count
    );

    modport slave (
        input  if_pc, ex_upd_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_hit, pred_taken, pred_target, mispredict, br_count, mis_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: a direction table of saturating counters combined
// with a tagged branch target buffer.
// The IF stage looks up if_pc combinationally, in the same cycle as the fetch.
// The EX stage trains the table with each resolved branch and raises mispredict.
// Optional feature: define BP_GSHARE_EN to XOR a global history register into the index.
module branch_predictor #(
    parameter int ENTRIES = 64,   // power of two, >= 4
    parameter int CNT_W   = 2,    // 1..4
    parameter int TAG_W   = 8
) (
    input  logic          clk,
    input  logic          reset,  // asynchronous, active-low
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [31:0]      CNT32_MAX = '1;

    // Table storage: valid and counter have defined reset values, tag and target do not
    logic                valid_q [ENTRIES];
    logic [CNT_W-1:0]    cnt_q   [ENTRIES];
    logic [TAG_W-1:0]    tag_q   [ENTRIES];
    logic [31:0]         tgt_q   [ENTRIES];

    logic [31:0]         br_count_q;
    logic [31:0]         mis_count_q;

    logic [IDX_W-1:0]    lk_idx;
    logic [TAG_W-1:0]    lk_tag;
    logic                lk_hit;
    logic [IDX_W-1:0]    up_idx;
    logic [TAG_W-1:0]    up_tag;
    logic                up_hit;
    logic                mis;

`ifdef BP_GSHARE_EN
    logic [IDX_W-1:0]    ghr_q;

    assign lk_idx = bp.if_pc[IDX_W+1:2] ^ ghr_q;
    assign up_idx = bp.ex_pc[IDX_W+1:2] ^ ghr_q;

    // Global history shifts in the resolved outcome of every update (non-speculative)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ghr_q <= '0;
        end else if (bp.ex_upd_valid) begin
            ghr_q <= {ghr_q[IDX_W-2:0], bp.ex_taken};
        end
    end
`else
    assign lk_idx = bp.if_pc[IDX_W+1:2];
    assign up_idx = bp.ex_pc[IDX_W+1:2];
`endif

    // The tag always comes from the PC, even when the index is hashed with history
    assign lk_tag = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign up_tag = bp.ex_pc[IDX_W+TAG_W+1:IDX_W+2];

    // PC bits that play no part in indexing or tagging
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.ex_pc[31:IDX_W+TAG_W+2], bp.ex_pc[1:0], bp.if_pc[1:0]};

    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // Lookup reads the registered table, so an update in the same cycle is not visible yet
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
        bp.pred_hit    = lk_hit;
        bp.pred_taken  = 1'b0;
        bp.pred_target = bp.if_pc + 32'd4;
        if (lk_hit && cnt_q[lk_idx][CNT_W-1]) begin
            bp.pred_taken  = 1'b1;
            bp.pred_target = tgt_q[lk_idx];
        end
    end

    // A wrong direction is a mispredict; a right "taken" with the wrong target is too
    assign mis = bp.ex_upd_valid &&
                 ((bp.ex_taken != bp.ex_pred_taken) ||
                  (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
    assign bp.mispredict = mis;

    // Direction state: train the counter on a tag hit, allocate on a taken miss
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_WNT;
            end
        end else if (bp.ex_upd_valid) begin
            if (up_hit) begin
                if (bp.ex_taken) begin
                    cnt_q[up_idx] <= (cnt_q[up_idx] == CNT_MAX) ? CNT_MAX : cnt_q[up_idx] + CNT_W'(1);
                end else begin
                    cnt_q[up_idx] <= (cnt_q[up_idx] == '0) ? '0 : cnt_q[up_idx] - CNT_W'(1);
                end
            end else if (bp.ex_taken) begin
                valid_q[up_idx] <= 1'b1;
                cnt_q[up_idx]   <= CNT_WT;
            end
        end
    end

    // Tag and target: written on any taken update (a hit keeps the same tag, a miss replaces the entry)
    always_ff @(posedge clk) begin
        // NOTE: tag and target storage is not reset; an entry is meaningless until valid is set.
        if (bp.ex_upd_valid && bp.ex_taken) begin
            tag_q[up_idx] <= up_tag;
            tgt_q[up_idx] <= bp.ex_target;
        end
    end

    // Statistics counters, both saturating at all-ones
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count_q  <= '0;
            mis_count_q <= '0;
        end else if (bp.ex_upd_valid) begin
            if (br_count_q != CNT32_MAX) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (mis && (mis_count_q != CNT32_MAX)) begin
                mis_count_q <= mis_count_q + 32'd1;
            end
        end
    end

    assign bp.br_count  = br_count_q;
    assign bp.mis_count = mis_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor (ENTRIES=64, CNT_W=2, TAG_W=8, default build).
// The stimulus process drives one cycle at a time and queues the expected outputs.
// The monitor pops and compares them on the falling edge.
module tb_branch_predictor;
    logic clk;
    logic reset;

    branch_predictor_if bp ();

    branch_predictor #(.ENTRIES(64), .CNT_W(2), .TAG_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        hit;
        logic        taken;
        logic [31:0] target;
        logic        mis;
        logic [31:0] br;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    localparam logic [31:0] PC_A = 32'h0040_0010;  // idx 4, tag 0x00
    localparam logic [31:0] PC_B = 32'h0040_0110;  // idx 4, tag 0x01

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".hit"},       {31'd0, bp.pred_hit},   {31'd0, e.hit});
                check({e.name, ".taken"},     {31'd0, bp.pred_taken}, {31'd0, e.taken});
                check({e.name, ".target"},    bp.pred_target,         e.target);
                check({e.name, ".mispredict"},{31'd0, bp.mispredict}, {31'd0, e.mis});
                check({e.name, ".br_count"},  bp.br_count,            e.br);
                check({e.name, ".mis_count"}, bp.mis_count,           e.mc);
            end
        end
    end

    task automatic push(input string name, input logic hit, input logic tk, input logic [31:0] tgt,
                        input logic mis, input logic [31:0] br, input logic [31:0] mc);
        exp_t e;
        e.name = name; e.hit = hit; e.taken = tk; e.target = tgt;
        e.mis = mis; e.br = br; e.mc = mc;
        sb.push_back(e);
    endtask

    // One cycle: drive inputs after the rising edge, queue expectation, return after the falling edge
    task automatic cycle(input string name, input logic [31:0] pc,
                         input logic upd, input logic [31:0] xpc, input logic xt,
                         input logic [31:0] xtgt, input logic xpt, input logic [31:0] xptgt,
                         input logic e_hit, input logic e_tk, input logic [31:0] e_tgt,
                         input logic e_mis, input logic [31:0] e_br, input logic [31:0] e_mc);
        @(posedge clk);
        #1;
        bp.if_pc          = pc;
        bp.ex_upd_valid   = upd;
        bp.ex_pc          = xpc;
        bp.ex_taken       = xt;
        bp.ex_target      = xtgt;
        bp.ex_pred_taken  = xpt;
        bp.ex_pred_target = xptgt;
        push(name, e_hit, e_tk, e_tgt, e_mis, e_br, e_mc);
        @(negedge clk);
        #1;
    endtask

    // Idle cycle: no update; ex_taken differs from ex_pred_taken to show mispredict is gated by valid
    task automatic idle(input string name, input logic [31:0] pc,
                        input logic e_hit, input logic e_tk, input logic [31:0] e_tgt,
                        input logic [31:0] e_br, input logic [31:0] e_mc);
        cycle(name, pc, 1'b0, pc, 1'b1, 32'h0, 1'b0, 32'h0, e_hit, e_tk, e_tgt, 1'b0, e_br, e_mc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset             = 1'b0;
        bp.if_pc          = PC_A;
        bp.ex_upd_valid   = 1'b0;
        bp.ex_pc          = '0;
        bp.ex_taken       = 1'b0;
        bp.ex_target      = '0;
        bp.ex_pred_taken  = 1'b0;
        bp.ex_pred_target = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // T1: reset state
        idle("t1_reset", PC_A, 0, 0, 32'h0040_0014, 0, 0);
        // T2: taken update allocates; mispredict in the same cycle
        cycle("t2_alloc", PC_A, 1, PC_A, 1, 32'h0040_0100, 0, 32'h0, 0, 0, 32'h0040_0014, 1, 0, 0);
        idle("t2_after", PC_A, 1, 1, 32'h0040_0100, 1, 1);
        // T3: counter walks down and saturates at 0
        cycle("t3_nt1", PC_A, 1, PC_A, 0, 32'h0, 1, 32'h0040_0100, 1, 1, 32'h0040_0100, 1, 1, 1);
        cycle("t3_nt2", PC_A, 1, PC_A, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0040_0014, 0, 2, 2);
        cycle("t3_nt3", PC_A, 1, PC_A, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0040_0014, 0, 3, 2);
        cycle("t3_nt4", PC_A, 1, PC_A, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0040_0014, 0, 4, 2);
        // Two taken updates climb 0 -> 1 -> 2
        cycle("t3_t1", PC_A, 1, PC_A, 1, 32'h0040_0100, 0, 32'h0, 1, 0, 32'h0040_0014, 1, 5, 2);
        cycle("t3_t2", PC_A, 1, PC_A, 1, 32'h0040_0100, 0, 32'h0, 1, 0, 32'h0040_0014, 1, 6, 3);
        // Correct direction, wrong target: still a mispredict
        cycle("t3_badtgt", PC_A, 1, PC_A, 1, 32'h0040_0100, 1, 32'h0040_0200, 1, 1, 32'h0040_0100, 1, 7, 4);
        // Counter at 3 clamps; target retrained to 0x180
        cycle("t3_sat_hi", PC_A, 1, PC_A, 1, 32'h0040_0180, 1, 32'h0040_0180, 1, 1, 32'h0040_0100, 0, 8, 5);
        cycle("t3_after_sat", PC_A, 1, PC_A, 0, 32'h0, 1, 32'h0040_0180, 1, 1, 32'h0040_0180, 1, 9, 5);
        // T4: aliasing at idx 4 with a different tag
        idle("t4_alias_miss", PC_B, 0, 0, 32'h0040_0114, 10, 6);
        cycle("t4_nt_miss", PC_B, 1, PC_B, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0040_0114, 0, 10, 6);
        idle("t4_a_kept", PC_A, 1, 1, 32'h0040_0180, 11, 6);
        cycle("t4_replace", PC_B, 1, PC_B, 1, 32'h0040_0300, 0, 32'h0, 0, 0, 32'h0040_0114, 1, 11, 6);
        idle("t4_a_evicted", PC_A, 0, 0, 32'h0040_0014, 12, 7);
        idle("t4_b_hit", PC_B, 1, 1, 32'h0040_0300, 12, 7);
        // T5: same-cycle lookup sees old entry, next cycle sees new
        cycle("t5_same_cyc", PC_B, 1, PC_B, 0, 32'h0, 1, 32'h0040_0300, 1, 1, 32'h0040_0300, 1, 12, 7);
        cycle("t5_next_cyc", PC_B, 1, PC_B, 1, 32'h0040_0400, 0, 32'h0, 1, 0, 32'h0040_0114, 1, 13, 8);
        // Reset asserted while that update is still presented: it must not land
        reset = 1'b0;
        push("t5_mid_reset", 0, 0, 32'h0040_0114, 1, 0, 0);
        @(negedge clk);
        #1;
        bp.ex_upd_valid = 1'b0;
        reset = 1'b1;
        idle("t5_post_reset", PC_B, 0, 0, 32'h0040_0114, 0, 0);
        // Fresh allocation after reset predicts taken immediately
        cycle("t5_realloc", PC_A, 1, PC_A, 1, 32'h0040_0500, 1, 32'h0040_0500, 0, 0, 32'h0040_0014, 0, 0, 0);
        idle("t5_realloc_hit", PC_A, 1, 1, 32'h0040_0500, 1, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
